// File: rtl/i8255_pkg.sv
// Shared definitions for the i8255 handshake ports: FSM state encoding and default port width.
package i8255_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_STROBED = 2'd1,
    ST_FULL    = 2'd2,
    ST_READING = 2'd3
  } state_t;

endpackage : i8255_pkg

// File: rtl/i8255_sync2.sv
// Parameterised-width two-flop synchronizer with a configurable reset value.
module i8255_sync2 #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // NOTE: non-blocking assignments here so both stages sample their pre-edge inputs and the chain really is two flops deep.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule : i8255_sync2

// File: rtl/i8255_strobed_in.sv
// Mode-1 strobed input port: latches the peripheral byte on stb_n fall and runs the IBF/INTR handshake.
// Define I8255_STB_SYNC_EN to put 2-flop synchronizers on stb_n and pin_d.
module i8255_strobed_in
  import i8255_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pin_d,
  input  logic             stb_n,
  input  logic             rd_n,
  input  logic             inte_we,
  input  logic             inte_d,
  output logic [WIDTH-1:0] dout,
  output logic             ibf,
  output logic             intr,
  output logic             inte,
  output logic             ovr
);

  logic             stb_s;
  logic [WIDTH-1:0] pin_s;

`ifdef I8255_STB_SYNC_EN
  i8255_sync2 #(.WIDTH(1), .RST_VAL(1'b1)) u_stb_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (stb_n),
    .q       (stb_s)
  );

  i8255_sync2 #(.WIDTH(WIDTH), .RST_VAL('0)) u_pin_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pin_d),
    .q       (pin_s)
  );
`else
  assign stb_s = stb_n;
  assign pin_s = pin_d;
`endif

  state_t           state_q, state_d;
  logic             stb_prev_q, stb_prev_d;
  logic             rd_prev_q, rd_prev_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             inte_en_q, inte_en_d;
  logic             ovr_q, ovr_d;

  logic stb_fall, stb_rise, rd_fall, rd_rise;

  always_comb begin
    stb_fall = stb_prev_q & ~stb_s;
    stb_rise = ~stb_prev_q & stb_s;
    rd_fall  = rd_prev_q & ~rd_n;
    rd_rise  = ~rd_prev_q & rd_n;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    dout_d     = dout_q;
    ovr_d      = ovr_q;
    inte_en_d  = inte_we ? inte_d : inte_en_q;
    stb_prev_d = stb_s;
    rd_prev_d  = rd_n;

    // A new strobe beats any read in progress, including a coincident rd_n rise.
    if (stb_fall) begin
      dout_d  = pin_s;
      state_d = ST_STROBED;
      if (state_q != ST_EMPTY) ovr_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_STROBED: if (stb_rise) state_d = ST_FULL;
        ST_FULL:    if (rd_fall)  state_d = ST_READING;
        ST_READING: if (rd_rise) begin
          state_d = ST_EMPTY;
          ovr_d   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // History flops reset to 1 so an idle-high strobe is not seen as a fall after reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_EMPTY;
      stb_prev_q <= 1'b1;
      rd_prev_q  <= 1'b1;
      dout_q     <= '0;
      inte_en_q  <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      stb_prev_q <= stb_prev_d;
      rd_prev_q  <= rd_prev_d;
      dout_q     <= dout_d;
      inte_en_q  <= inte_en_d;
      ovr_q      <= ovr_d;
    end
  end

  assign dout = dout_q;
  assign ibf  = (state_q != ST_EMPTY);
  assign intr = (state_q == ST_FULL) & inte_en_q;
  assign inte = inte_en_q;
  assign ovr  = ovr_q;

endmodule : i8255_strobed_in

// File: tb/tb_i8255_strobed_in.sv
// Self-checking bench for i8255_strobed_in: per-cycle comparison against a buffer-level model plus literal spot checks.
module tb_i8255_strobed_in;

`ifdef I8255_STB_SYNC_EN
  localparam int STB_LAT = 3;
`else
  localparam int STB_LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] pin_d;
  logic       stb_n;
  logic       rd_n;
  logic       inte_we;
  logic       inte_d;
  logic [7:0] dout;
  logic       ibf, intr, inte, ovr;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  i8255_strobed_in #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pin_d   (pin_d),
    .stb_n   (stb_n),
    .rd_n    (rd_n),
    .inte_we (inte_we),
    .inte_d  (inte_d),
    .dout    (dout),
    .ibf     (ibf),
    .intr    (intr),
    .inte    (inte),
    .ovr     (ovr)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Buffer-level model: a byte is either absent or held; while held the strobe may still be low,
  // and a CPU read may be underway. Interrupt is requested only for a settled, unread byte.
  bit       m_held, m_awaiting_stb_high, m_being_read, m_ovr, m_inte;
  bit [7:0] m_byte;
  bit       m_last_stb = 1'b1, m_last_rd = 1'b1;
  bit       m_stb_p1 = 1'b1, m_stb_p2 = 1'b1;
  bit [7:0] m_pin_p1, m_pin_p2;

  always @(posedge clk) begin
    bit       seen_stb;
    bit [7:0] seen_pin;
`ifdef I8255_STB_SYNC_EN
    seen_stb = m_stb_p2;
    seen_pin = m_pin_p2;
`else
    seen_stb = stb_n;
    seen_pin = pin_d;
`endif
    if (!reset_n) begin
      m_held = 0; m_awaiting_stb_high = 0; m_being_read = 0; m_ovr = 0; m_inte = 0;
      m_byte = 8'h00; m_last_stb = 1; m_last_rd = 1;
      m_stb_p1 = 1; m_stb_p2 = 1; m_pin_p1 = 8'h00; m_pin_p2 = 8'h00;
    end else begin
      if (inte_we) m_inte = inte_d;
      if (m_last_stb && !seen_stb) begin
        if (m_held) m_ovr = 1;
        m_held = 1; m_awaiting_stb_high = 1; m_being_read = 0; m_byte = seen_pin;
      end else if (m_awaiting_stb_high) begin
        if (seen_stb) m_awaiting_stb_high = 0;
      end else if (m_held && !m_being_read) begin
        if (m_last_rd && !rd_n) m_being_read = 1;
      end else if (m_being_read && !m_last_rd && rd_n) begin
        m_being_read = 0; m_held = 0; m_ovr = 0;
      end
      m_last_stb = seen_stb;
      m_last_rd  = rd_n;
      m_stb_p2 = m_stb_p1; m_stb_p1 = stb_n;
      m_pin_p2 = m_pin_p1; m_pin_p1 = pin_d;
    end
  end

  always @(posedge clk) begin
    #1;
    check("dout", dout, m_byte);
    check("ibf",  ibf,  m_held);
    check("intr", intr, m_held && !m_awaiting_stb_high && !m_being_read && m_inte);
    check("inte", inte, m_inte);
    check("ovr",  ovr,  m_ovr);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_inte(input logic v);
    inte_we = 1'b1; inte_d = v;
    tick(1);
    inte_we = 1'b0;
  endtask

  // Full strobe pulse, then enough idle cycles for the buffer to settle in FULL.
  task automatic strobe(input logic [7:0] b);
    pin_d = b; stb_n = 1'b0;
    tick(4);
    stb_n = 1'b1;
    tick(STB_LAT + 1);
  endtask

  task automatic cpu_read();
    rd_n = 1'b0;
    tick(2);
    rd_n = 1'b1;
    tick(1);
  endtask

  initial begin
    reset_n = 1'b0; pin_d = 8'h00; stb_n = 1'b1; rd_n = 1'b1; inte_we = 1'b0; inte_d = 1'b0;
    tick(2);
    check("rst_ibf",  ibf,  1'b0);
    check("rst_intr", intr, 1'b0);
    check("rst_ovr",  ovr,  1'b0);
    check("rst_dout", dout, 8'h00);
    reset_n = 1'b1;
    tick(1);

    // Basic handshake with INTE set.
    write_inte(1'b1);
    pin_d = 8'hA5; stb_n = 1'b0;
    tick(STB_LAT);
    check("a5_dout", dout, 8'hA5);
    check("a5_ibf",  ibf,  1'b1);
    check("a5_intr_low_during_strobe", intr, 1'b0);
    tick(4 - STB_LAT);
    stb_n = 1'b1;
    tick(STB_LAT);
    check("a5_intr", intr, 1'b1);
    rd_n = 1'b0;
    tick(1);
    check("rd_fall_intr", intr, 1'b0);
    check("rd_fall_ibf",  ibf,  1'b1);
    tick(1);
    rd_n = 1'b1;
    tick(1);
    check("rd_rise_ibf",  ibf,  1'b0);
    check("rd_keep_dout", dout, 8'hA5);

    // INTE clear: no interrupt until INTE is written while FULL.
    write_inte(1'b0);
    strobe(8'h77);
    check("inte0_intr", intr, 1'b0);
    check("inte0_ibf",  ibf,  1'b1);
    write_inte(1'b1);
    check("inte_set_intr", intr, 1'b1);
    write_inte(1'b0);
    check("inte_clr_intr", intr, 1'b0);
    cpu_read();

    // Overrun: second byte before any read.
    strobe(8'h3C);
    strobe(8'hC3);
    check("ovr_dout", dout, 8'hC3);
    check("ovr_flag", ovr,  1'b1);
    check("ovr_ibf",  ibf,  1'b1);
    cpu_read();
    check("ovr_cleared", ovr, 1'b0);
    check("ovr_read_ibf", ibf, 1'b0);

    // Read rise coincides with a new strobe fall.
    strobe(8'h11);
    rd_n = 1'b0;
    tick(2);
    rd_n = 1'b1; pin_d = 8'h5A; stb_n = 1'b0;
    tick(1);
`ifndef I8255_STB_SYNC_EN
    check("coinc_dout", dout, 8'h5A);
    check("coinc_ibf",  ibf,  1'b1);
    check("coinc_ovr",  ovr,  1'b1);
`endif
    tick(3);
    stb_n = 1'b1;
    tick(STB_LAT + 1);

    // Reset while READING.
    rd_n = 1'b0;
    tick(2);
    reset_n = 1'b0;
    tick(1);
    check("rst_rd_ibf",  ibf,  1'b0);
    check("rst_rd_intr", intr, 1'b0);
    check("rst_rd_ovr",  ovr,  1'b0);
    reset_n = 1'b1; rd_n = 1'b1;
    tick(2);

    // Reads while EMPTY are ignored.
    write_inte(1'b1);
    cpu_read();
    cpu_read();
    check("empty_rd_ibf",  ibf,  1'b0);
    check("empty_rd_intr", intr, 1'b0);
    check("empty_rd_ovr",  ovr,  1'b0);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_i8255_strobed_in
